// File: rtl/tone_phase_accum.sv
// Note-playback stage: accepts {increment, duration} notes and plays the MSB of a
// ripple-carry phase accumulator as a square-wave tone for exactly 'duration' cycles.

module FullAdder_GL (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic axb;
    assign axb  = a ^ b;
    assign s    = axb ^ cin;
    assign cout = (a & b) | (axb & cin);
endmodule

// Handshake: a note transfers on a rising edge with note_val & note_rdy; note_inc and
// note_dur are sampled only on that edge, and note_rdy is high exactly while IDLE.
module tone_phase_accum #(
    parameter int ACC_W = 16,
    parameter int DUR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_val,
    output logic             note_rdy,
    input  logic [ACC_W-1:0] note_inc,
    input  logic [DUR_W-1:0] note_dur,
    input  logic             stop,
    output logic             tone_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_q;
    logic [DUR_W-1:0] dur_q;
    logic             done_q;

    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] carry;
    logic             carry_unused;

    assign carry[0] = 1'b0;

    // Ripple chain; the final carry-out is the discarded wrap of the phase.
    for (genvar i = 0; i < ACC_W; i++) begin : g_add
        if (i == ACC_W - 1) begin : g_last
            FullAdder_GL u_fa (
                .a    (acc_q[i]),
                .b    (inc_q[i]),
                .cin  (carry[i]),
                .s    (acc_d[i]),
                .cout (carry_unused)
            );
        end else begin : g_mid
            FullAdder_GL u_fa (
                .a    (acc_q[i]),
                .b    (inc_q[i]),
                .cin  (carry[i]),
                .s    (acc_d[i]),
                .cout (carry[i+1])
            );
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            inc_q   <= '0;
            dur_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (note_val) begin
                        if (note_dur != '0) begin
                            acc_q   <= '0;
                            inc_q   <= note_inc;
                            dur_q   <= note_dur;
                            state_q <= PLAY;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    acc_q <= acc_d;
                    dur_q <= dur_q - 1'b1;
                    // stop and last-cycle share one exit so only a single done pulse results.
                    if (stop || (dur_q == DUR_W'(1))) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign note_rdy = (state_q == IDLE);
    assign busy     = (state_q == PLAY);
    assign tone_out = busy & acc_q[ACC_W-1];
    assign done     = done_q;

endmodule
